// File: rtl/cam_capture_ctrl.sv
// Frame-capture scheduler for the camera -> frame buffer path: decides which camera frames
// are written, gates the writer, clears its address at frame start and checks pixel counts.
module cam_capture_ctrl #(
    parameter int unsigned IMG_W       = 160,
    parameter int unsigned IMG_H       = 120,
    parameter int unsigned PX_CNT_W    = 15,
    parameter int unsigned FRAME_CNT_W = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cap_start,
    input  logic                   cap_cont,
    input  logic                   cap_stop,
    input  logic                   CAM_vsync,
    input  logic                   px_wr,
    output logic                   cap_en,
    output logic                   addr_clr,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic [PX_CNT_W-1:0]    px_count,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [PX_CNT_W-1:0] PX_FULL = PX_CNT_W'(IMG_W * IMG_H);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] vs_sync;
    logic                   vs_s, vs_d, vs_rise, vs_fall;
    logic                   stop_pending, ovf;
    logic                   frame_start, frame_end, px_inc, px_sat;
    logic [PX_CNT_W-1:0]    px_next;
    logic                   ovf_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_sync <= '0;
            vs_d    <= 1'b0;
        end else begin
            vs_sync <= {vs_sync[SYNC_STAGES-2:0], CAM_vsync};
            vs_d    <= vs_s;
        end
    end

    assign vs_s    = vs_sync[SYNC_STAGES-1];
    assign vs_rise = vs_s & ~vs_d;
    assign vs_fall = ~vs_s & vs_d;

    assign frame_start = (state == ARM) && !cap_stop && vs_fall;
    assign frame_end   = (state == CAPTURE) && vs_rise;
    assign px_inc      = (state == CAPTURE) && px_wr;
    assign px_sat      = (px_count == PX_FULL);

    // A pixel coinciding with the closing vsync edge must be reflected in frame_err.
    assign px_next  = (px_inc && !px_sat) ? px_count + PX_CNT_W'(1) : px_count;
    assign ovf_next = ovf | (px_inc & px_sat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!cap_stop && (cap_start || cap_cont)) state_nxt = ARM;
            ARM:     if (cap_stop) state_nxt = IDLE;
                     else if (vs_fall) state_nxt = CAPTURE;
            CAPTURE: if (vs_rise) state_nxt = DONE;
            DONE:    state_nxt = (cap_cont && !stop_pending && !cap_stop) ? ARM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cap_en     = (state == CAPTURE);
        busy       = (state != IDLE);
        frame_done = (state == DONE);
        addr_clr   = frame_start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_count     <= '0;
            ovf          <= 1'b0;
            stop_pending <= 1'b0;
            frame_err    <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            if (frame_start) begin
                px_count <= '0;
                ovf      <= 1'b0;
            end else if (state == DONE) begin
                ovf      <= 1'b0;
            end else begin
                px_count <= px_next;
                ovf      <= ovf_next;
            end
            if ((state == CAPTURE) && cap_stop) stop_pending <= 1'b1;
            else if (state == DONE)             stop_pending <= 1'b0;
            if (frame_end) begin
                frame_err <= (px_next != PX_FULL) || ovf_next;
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scoreboard bench for cam_capture_ctrl: a frame-level model predicts which camera frames are
// captured and what each capture reports; a monitor compares every frame_done against it.
module tb_cam_capture_ctrl;

    localparam int N = 160 * 120;

    logic        clk = 1'b0;
    logic        rst, cap_start, cap_cont, cap_stop, CAM_vsync, px_wr;
    logic        cap_en, addr_clr, busy, frame_done, frame_err;
    logic [14:0] px_count;
    logic [7:0]  frame_cnt;

    always #5 clk = ~clk;

    cam_capture_ctrl #(
        .IMG_W(160), .IMG_H(120), .PX_CNT_W(15), .FRAME_CNT_W(8), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .cap_start(cap_start), .cap_cont(cap_cont), .cap_stop(cap_stop),
        .CAM_vsync(CAM_vsync), .px_wr(px_wr), .cap_en(cap_en), .addr_clr(addr_clr),
        .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
        .px_count(px_count), .frame_cnt(frame_cnt)
    );

    typedef struct {
        int px;
        bit err;
        int fcnt;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    // Frame-level model: armed means the next vsync fall starts a captured frame.
    bit m_armed = 1'b0, m_capt = 1'b0, m_cont = 1'b0;
    int m_fcnt = 0, m_px = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per frame_done; frame_cnt is checked a cycle later.
    int clr_seen = 0;
    bit fcnt_pending = 1'b0;
    int fcnt_exp = 0;
    bit en_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            clr_seen     = 0;
            fcnt_pending = 1'b0;
            en_prev      = 1'b0;
        end else begin
            if (fcnt_pending) begin
                check("frame_cnt", 32'(frame_cnt), 32'(fcnt_exp));
                fcnt_pending = 1'b0;
            end
            if (addr_clr) clr_seen++;
            if (cap_en && !en_prev) check("cap_en_rise_vsync_low", 32'(CAM_vsync), 0);
            en_prev = cap_en;
            if (frame_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame_done", 32'(frame_done), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("px_count_at_done", 32'(px_count), 32'(e.px));
                    check("frame_err", 32'(frame_err), 32'(e.err));
                    check("addr_clr_count", 32'(clr_seen), 1);
                    fcnt_pending = 1'b1;
                    fcnt_exp     = e.fcnt;
                end
                clr_seen = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_cmd(input bit s, input bit p);
        cap_start = s;
        cap_stop  = p;
        tick(1);
        cap_start = 1'b0;
        cap_stop  = 1'b0;
        if (!m_capt) begin
            if (p) m_armed = m_cont;
            else if (s || m_cont) m_armed = 1'b1;
        end
    endtask

    task automatic set_cont(input bit v);
        cap_cont = v;
        m_cont   = v;
        if (v && !m_capt) m_armed = 1'b1;
        tick(1);
    endtask

    // 0 none, 1 start, 2 stop, 3 start+stop, 4 stop with cont dropped, 5 cont on, 6 cont off
    task automatic issue(input int c);
        case (c)
            1: pulse_cmd(1'b1, 1'b0);
            2: pulse_cmd(1'b0, 1'b1);
            3: pulse_cmd(1'b1, 1'b1);
            4: begin
                cap_cont = 1'b0;
                m_cont   = 1'b0;
                pulse_cmd(1'b0, 1'b1);
            end
            5: set_cont(1'b1);
            6: set_cont(1'b0);
            default: tick(1);
        endcase
    endtask

    task automatic run_frame(input int n, input int mid, input int blank, input bit gaps);
        exp_t e;
        bit   capt;
        CAM_vsync = 1'b0;
        capt      = m_armed;
        m_armed   = 1'b0;
        m_capt    = capt;
        if (capt) begin
            m_fcnt = (m_fcnt + 1) % 256;
            e.px   = (n > N) ? N : n;
            e.err  = (n != N);
            e.fcnt = m_fcnt;
            sb.push_back(e);
        end
        tick(6);
        for (int i = 0; i < n; i++) begin
            px_wr = 1'b1;
            tick(1);
            px_wr = 1'b0;
            if (gaps) tick($urandom_range(0, 2));
            if (mid != 0 && i == n / 2) issue(mid);
        end
        if (mid != 0 && n == 0) issue(mid);
        tick(4);
        CAM_vsync = 1'b1;
        if (capt) begin
            m_px    = e.px;
            m_armed = m_cont;
            m_capt  = 1'b0;
        end
        tick(12);
        check("busy_in_blanking", 32'(busy), 32'(m_armed));
        check("px_count_hold", 32'(px_count), 32'(m_px));
        repeat (3) begin
            px_wr = 1'b1;
            tick(1);
            px_wr = 1'b0;
            tick(1);
        end
        issue(blank);
        tick(8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cap_start = 1'b0; cap_cont = 1'b0; cap_stop = 1'b0;
        CAM_vsync = 1'b1; px_wr = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(5);
        check("rst_cap_en", 32'(cap_en), 0);
        check("rst_addr_clr", 32'(addr_clr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_px_count", 32'(px_count), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);

        // Single full snapshot
        issue(1);
        tick(4);
        run_frame(N, 0, 0, 1'b0);

        // Armed mid-frame: this frame is skipped, the next one captured
        run_frame(9, 1, 0, 1'b1);
        run_frame(30, 0, 0, 1'b1);

        // Continuous for three frames, stop mid-frame four
        issue(5);
        tick(4);
        for (int f = 0; f < 3; f++) run_frame($urandom_range(0, 40), 0, 0, 1'b1);
        run_frame(20, 4, 0, 1'b1);

        // Short and long frames
        issue(1);
        tick(4);
        run_frame(N - 1, 0, 1, 1'b0);
        run_frame(N + 1, 0, 0, 1'b0);

        // Reset in the middle of a captured frame
        issue(1);
        tick(4);
        CAM_vsync = 1'b0;
        tick(6);
        repeat (10) begin
            px_wr = 1'b1;
            tick(1);
            px_wr = 1'b0;
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_mid_cap_en", 32'(cap_en), 0);
        check("rst_mid_busy", 32'(busy), 0);
        m_armed = 1'b0; m_capt = 1'b0; m_fcnt = 0; m_px = 0;
        tick(2);
        rst = 1'b0;
        repeat (5) begin
            px_wr = 1'b1;
            tick(1);
            px_wr = 1'b0;
        end
        tick(4);
        CAM_vsync = 1'b1;
        tick(12);
        check("rst_mid_frame_cnt", 32'(frame_cnt), 0);
        check("rst_mid_px_count", 32'(px_count), 0);

        // Start and stop together in IDLE
        issue(3);
        tick(2);
        check("start_stop_idle_busy", 32'(busy), 32'(m_armed));
        tick(6);

        // 256 continuous frames wrap the frame counter
        issue(5);
        tick(4);
        for (int f = 0; f < 256; f++) run_frame($urandom_range(0, 3), 0, 0, 1'b0);
        issue(4);
        tick(6);

        // Randomized commands in blanking and mid-frame
        for (int f = 0; f < 40; f++)
            run_frame($urandom_range(0, 40), $urandom_range(0, 6), $urandom_range(0, 6), 1'b1);
        issue(4);
        tick(20);
        check("no_pending_frames", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
